// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: Y86-64 icodes, memory geometry
// and the arbiter state encoding.
package dmem_pkg;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_req_decode.sv
// Turns a memory-stage instruction into a memory command: whether it touches
// memory, whether it writes, and which address/data it uses.
module dmem_req_decode (
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        access,
  output logic        we,
  output logic [63:0] addr,
  output logic [63:0] wdata
);
  import dmem_pkg::*;

  always_comb begin
    access = 1'b0;
    we     = 1'b0;
    addr   = '0;
    wdata  = '0;
    case (icode)
      ICODE_RMMOVQ, ICODE_PUSHQ: begin
        access = 1'b1;
        we     = 1'b1;
        addr   = valE;
        wdata  = valA;
      end
      ICODE_CALL: begin
        access = 1'b1;
        we     = 1'b1;
        addr   = valE;
        wdata  = valP;
      end
      ICODE_MRMOVQ: begin
        access = 1'b1;
        addr   = valE;
      end
      // ret/popq read through the old stack pointer held in valA
      ICODE_RET, ICODE_POPQ: begin
        access = 1'b1;
        addr   = valA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU memory
// stage and a loader/debug port; each grant runs IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
  parameter int DEPTH = dmem_pkg::DEPTH,
  parameter int AW    = dmem_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [3:0]    cpu_icode,
  input  logic [63:0]   cpu_valA,
  input  logic [63:0]   cpu_valE,
  input  logic [63:0]   cpu_valP,
  output logic          cpu_done,
  output logic [63:0]   cpu_valM,
  output logic          cpu_err,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [63:0]   ld_addr,
  input  logic [63:0]   ld_wdata,
  output logic          ld_done,
  output logic [63:0]   ld_rdata,
  output logic          ld_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata,
  output logic          busy
);
  import dmem_pkg::*;

  state_t        state_reg, state_next;
  logic          last_grant_reg;
  logic          cmd_port_reg, cmd_access_reg, cmd_we_reg, cmd_err_reg;
  logic [AW-1:0] cmd_addr_reg;
  logic [63:0]   cmd_wdata_reg;

  logic          dec_access, dec_we;
  logic [63:0]   dec_addr, dec_wdata;
  logic          any_req, grant_ld;
  logic          sel_access, sel_we, sel_err;
  logic [63:0]   sel_addr, sel_wdata;
  logic          in_access, in_resp, resp_read;

  dmem_req_decode u_decode (
    .icode  (cpu_icode),
    .valA   (cpu_valA),
    .valE   (cpu_valE),
    .valP   (cpu_valP),
    .access (dec_access),
    .we     (dec_we),
    .addr   (dec_addr),
    .wdata  (dec_wdata)
  );

  // Loader wins when alone, or on a tie when the CPU was served last.
  assign any_req  = cpu_req | ld_req;
  assign grant_ld = ld_req & (~cpu_req | (last_grant_reg == PORT_CPU));

  always_comb begin
    sel_access = dec_access;
    sel_we     = dec_we;
    sel_addr   = dec_addr;
    sel_wdata  = dec_wdata;
    if (grant_ld) begin
      sel_access = 1'b1;
      sel_we     = ld_we;
      sel_addr   = ld_addr;
      sel_wdata  = ld_wdata;
    end
    // Full 64-bit compare so high address bits cannot alias into the RAM.
    sel_err = sel_access & (sel_addr > 64'(DEPTH - 1));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (any_req) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= PORT_LD;
      cmd_port_reg   <= PORT_CPU;
      cmd_access_reg <= 1'b0;
      cmd_we_reg     <= 1'b0;
      cmd_err_reg    <= 1'b0;
      cmd_addr_reg   <= '0;
      cmd_wdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && any_req) begin
        last_grant_reg <= grant_ld;
        cmd_port_reg   <= grant_ld;
        cmd_access_reg <= sel_access;
        cmd_we_reg     <= sel_we;
        cmd_err_reg    <= sel_err;
        cmd_addr_reg   <= sel_addr[AW-1:0];
        cmd_wdata_reg  <= sel_wdata;
      end
    end
  end

  // Outputs decode straight from registers so a reset clears them at once.
  assign in_access = (state_reg == ST_ACCESS);
  assign in_resp   = (state_reg == ST_RESP);
  assign busy      = (state_reg != ST_IDLE);

  assign mem_en    = in_access & cmd_access_reg & ~cmd_err_reg;
  assign mem_we    = mem_en & cmd_we_reg;
  assign mem_addr  = in_access ? cmd_addr_reg : '0;
  assign mem_wdata = in_access ? cmd_wdata_reg : '0;

  assign resp_read = in_resp & cmd_access_reg & ~cmd_we_reg & ~cmd_err_reg;

  assign cpu_done  = in_resp & (cmd_port_reg == PORT_CPU);
  assign cpu_err   = cpu_done & cmd_err_reg;
  assign cpu_valM  = (cpu_done & resp_read) ? mem_rdata : '0;

  assign ld_done   = in_resp & (cmd_port_reg == PORT_LD);
  assign ld_err    = ld_done & cmd_err_reg;
  assign ld_rdata  = (ld_done & resp_read) ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 1024, data-memory depth in 64-bit words; the legal address range is 0..DEPTH-1.
REQ-002 Parameter AW, default 10, memory address width, equal to clog2(DEPTH).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cpu_req  in  1  memory-stage request; held high until cpu_done.
REQ-006 cpu_icode  in  4  instruction code of the requesting instruction.
REQ-007 cpu_valA, cpu_valE, cpu_valP  in  64 each  memory-stage operands.
REQ-008 cpu_done  out  1  one-cycle completion pulse.
REQ-009 cpu_valM  out  64  read data, valid while cpu_done is high.
REQ-010 cpu_err  out  1  dmem_error, valid while cpu_done is high.
REQ-011 ld_req  in  1  loader/debug request; held high until ld_done.
REQ-012 ld_we  in  1  loader access type: 1 = write, 0 = read.
REQ-013 ld_addr, ld_wdata  in  64 each  loader address and write data.
REQ-014 ld_done  out  1  one-cycle completion pulse.
REQ-015 ld_rdata  out  64  read data, valid while ld_done is high.
REQ-016 ld_err  out  1  address error, valid while ld_done is high.
REQ-017 mem_en, mem_we  out  1 each  single-port RAM enable and write strobe.
REQ-018 mem_addr  out  AW  RAM word address.
REQ-019 mem_wdata  out  64  RAM write data.
REQ-020 mem_rdata  in  64  RAM read data, valid the cycle after mem_en with mem_we=0.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states: IDLE -> ACCESS -> RESP -> IDLE. Every accepted request spends exactly one cycle in each of ACCESS and RESP.
REQ-023 In IDLE with at least one request pending, the arbiter latches the winning command and moves to ACCESS on the next edge. With no request pending it stays in IDLE.
REQ-024 Winner selection:
  - If only one port requests, that port wins.
  - If both request, the winner is the port not served last (round-robin, tracked by a last_grant bit).
REQ-025 CPU icode decode:
  - 4 (rmmovq) and A (pushq): write valA to valE.
  - 8 (call): write valP to valE.
  - 5 (mrmovq): read from valE.
  - 9 (ret) and B (popq): read from valA.
  - Any other icode: no-access.
REQ-026 Address error: the selected 64-bit address, compared as unsigned, is greater than DEPTH-1.
REQ-027 In ACCESS, mem_en is 1 unless the command is an error or no-access. mem_we is 1 for writes. mem_addr carries the low AW address bits. mem_wdata carries the write data.
REQ-028 Outside ACCESS, mem_en and mem_we are 0.
REQ-029 In RESP, the granted port's done is 1, and the other port's done is 0.
  - Read data output equals mem_rdata for reads, and 0 for writes, errors, and no-access commands.
  - err is 1 only for an address error.
REQ-030 The RESP -> IDLE transition ignores request inputs. A requester drops req in the cycle after its done pulse.
REQ-031 A request arriving while busy waits. Outputs are unaffected until that request is arbitrated in IDLE.
REQ-032 An erroring access never asserts mem_en, so RAM contents stay unchanged.

Reset
REQ-033 On rst: state = IDLE, last_grant = loader (so the CPU wins the first tie), and all outputs = 0.
REQ-034 A reset during ACCESS or RESP aborts the operation immediately: no done pulse, and mem_en drops asynchronously.

Structure
REQ-035 The shared package dmem_pkg holds the icode constants (NOP..POPQ), DEPTH, AW, and the state enumeration.
REQ-036 Icode decoding sits in a combinational sub-module dmem_req_decode. It maps (icode, valA, valE, valP) to {access, we, addr, wdata}.

Verification
REQ-037 CPU rmmovq, valE=5, valA=0xAB:
  - mem_en=1, mem_we=1, mem_addr=5 in ACCESS.
  - cpu_done is the 2nd cycle after acceptance, with cpu_err=0.
REQ-038 Loader read at address 5 after REQ-037:
  - ld_rdata=0xAB with ld_done.
  - mem_we=0.
REQ-039 Both ports request in the same cycle after reset:
  - The CPU is served first, the loader second.
  - The next simultaneous pair is served loader first.
REQ-040 CPU mrmovq with valE=1024:
  - mem_en stays 0.
  - cpu_done with cpu_err=1 and cpu_valM=0.
REQ-041 CPU icode 6 (OPq): cpu_done with err=0, and mem_en never asserts.
REQ-042 rst asserted during ACCESS of a write: mem_en falls immediately, no done pulse, busy=0, and the location keeps its old value.
